debounce_bank: RTL and testbench



---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_chan.sv | 110 +++++++++++
 rtl/debounce_bank.sv | 57 +++++
 tb/tb_debounce_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch/button debouncer bank.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    localparam int unsigned DB_STABLE_CNT_DEF = 10;
    localparam int unsigned DB_CNT_W_DEF      = 8;

    // The accepted level is high while sitting in HIGH or while confirming a release.
    function automatic logic db_level(input db_state_t st);
        return (st == HIGH) || (st == FALL_CHK);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: two-flop synchroniser, confirm FSM with reload
// down-counter, and registered level/rise/fall outputs.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W      = DB_CNT_W_DEF,
    parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic bn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_nxt_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CNT - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state logic; the zero check comes before the decrement so cnt never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW: begin
                if (sync2_q) begin
                    state_d = RISE_CHK;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = LOW;
                end
            end
            RISE_CHK: begin
                if (!sync2_q) begin
                    state_d = LOW;
                end else if (tick_i && (cnt_q == '0)) begin
                    state_d = HIGH;
                    rise_d  = 1'b1;
                end else if (tick_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = FALL_CHK;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = HIGH;
                end
            end
            FALL_CHK: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (tick_i && (cnt_q == '0)) begin
                    state_d = LOW;
                    fall_d  = 1'b1;
                end else if (tick_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        level_d = db_level(state_d);
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= bn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign rise_nxt_o = rise_d;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debouncers with a registered any-rise summary
// aligned to the per-channel rise pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH       = 16,
    parameter int unsigned CNT_W      = DB_CNT_W_DEF,
    parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tick_i,
    input  logic [N_CH-1:0] bn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            any_rise_o
);

    if ((STABLE_CNT < 1) || (STABLE_CNT > (2**CNT_W) - 1)) begin : g_bad_stable_cnt
        $error("debounce_bank: STABLE_CNT out of range for CNT_W");
    end
    if ((N_CH < 1) || (N_CH > 32)) begin : g_bad_n_ch
        $error("debounce_bank: N_CH must be 1..32");
    end

    logic [N_CH-1:0] rise_nxt_s;
    logic            any_rise_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_chan #(
            .CNT_W      (CNT_W),
            .STABLE_CNT (STABLE_CNT)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .tick_i     (tick_i),
            .bn_i       (bn_i[g]),
            .level_o    (level_o[g]),
            .rise_o     (rise_o[g]),
            .fall_o     (fall_o[g]),
            .rise_nxt_o (rise_nxt_s[g])
        );
    end

    // Summary flag registered from the same next-cycle rise terms as rise_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            any_rise_q <= 1'b0;
        end else begin
            any_rise_q <= |rise_nxt_s;
        end
    end

    assign any_rise_o = any_rise_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and randomized bench for debounce_bank with a tick-counting reference model.
module tb_debounce_bank;

    localparam int N  = 16;
    localparam int SC = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [N-1:0] bn;
    logic [N-1:0] level, rise, fall;
    logic         any_rise;
    logic [3:0]   bn2, level2, rise2, fall2;
    logic         any2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(N), .CNT_W(8), .STABLE_CNT(SC)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .bn_i(bn),
        .level_o(level), .rise_o(rise), .fall_o(fall), .any_rise_o(any_rise)
    );

    debounce_bank #(.N_CH(4), .CNT_W(2), .STABLE_CNT(1)) dut_min (
        .clk_i(clk), .rst_i(rst), .tick_i(1'b1), .bn_i(bn2),
        .level_o(level2), .rise_o(rise2), .fall_o(fall2), .any_rise_o(any2)
    );

    // Reference model: 2-cycle input delay, then a pending flag that counts ticks
    // while the delayed input disagrees with the accepted level.
    logic [N-1:0] m_d1, m_d2, m_lvl, m_pend, m_rise, m_fall;
    logic         m_any;
    int           m_ticks [N];

    task automatic model_edge();
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pend = '0;
            m_rise = '0; m_fall = '0; m_any = 1'b0;
            for (int i = 0; i < N; i++) m_ticks[i] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (!m_pend[i]) begin
                    if (m_d2[i] != m_lvl[i]) begin
                        m_pend[i]  = 1'b1;
                        m_ticks[i] = 0;
                    end
                end else if (m_d2[i] == m_lvl[i]) begin
                    m_pend[i] = 1'b0;
                end else if (tick) begin
                    m_ticks[i] = m_ticks[i] + 1;
                    if (m_ticks[i] == SC) begin
                        m_lvl[i]  = m_d2[i];
                        m_pend[i] = 1'b0;
                        if (m_d2[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end
            m_any = |m_rise;
            m_d2  = m_d1;
            m_d1  = bn;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_level", level, m_lvl);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
        chk("model_any_rise", any_rise, m_any);
    endtask

    int fall_e;
    int npulse;

    initial begin
        rst  = 1'b1;
        tick = 1'b1;
        bn   = '1;
        bn2  = '1;
        repeat (3) cycle();
        chk("reset_level", level, 16'h0);
        chk("reset_rise", rise, 16'h0);
        chk("reset_fall", fall, 16'h0);
        chk("reset_any", any_rise, 1'b0);
        chk("reset_min_level", level2, 4'h0);

        // Inputs already high at release behave as new presses.
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            cycle();
            chk("rel_level", level, (e >= 13) ? 16'hFFFF : 16'h0);
            chk("rel_rise", rise, (e == 13) ? 16'hFFFF : 16'h0);
            chk("rel_any", any_rise, (e == 13) ? 1'b1 : 1'b0);
            chk("min_rise", rise2, (e == 4) ? 4'hF : 4'h0);
            chk("min_level", level2, (e >= 4) ? 4'hF : 4'h0);
            chk("min_any", any2, (e == 4) ? 1'b1 : 1'b0);
            chk("min_fall", fall2, 4'h0);
        end

        // Bounce on channel 0: 5 high, 1 low, then steady high.
        bn = '0;
        repeat (20) cycle();
        bn[0] = 1'b1;
        repeat (5) begin
            cycle();
            chk("bounce_burst_rise", rise[0], 1'b0);
        end
        bn[0] = 1'b0;
        cycle();
        chk("bounce_gap_rise", rise[0], 1'b0);
        bn[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            cycle();
            chk("bounce_rise", rise[0], (e == 13) ? 1'b1 : 1'b0);
        end

        // Release channel 3 with tick 1-in-4; first counting tick lands on edge 7.
        bn[3] = 1'b1;
        repeat (20) cycle();
        fall_e = -1;
        npulse = 0;
        bn[3]  = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick = ((e % 4) == 3) ? 1'b1 : 1'b0;
            cycle();
            if (fall[3]) begin
                npulse++;
                if (fall_e < 0) fall_e = e;
            end
        end
        tick = 1'b1;
        chk("gated_fall_edge", fall_e, 43);
        chk("gated_fall_count", npulse, 1);
        chk("gated_level_low", level[3], 1'b0);

        // Simultaneous presses on channels 1 and 15.
        bn[1]  = 1'b1;
        bn[15] = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            cycle();
            chk("simul_rise", rise, (e == 13) ? 16'h8002 : 16'h0);
            chk("simul_any", any_rise, (e == 13) ? 1'b1 : 1'b0);
        end

        // Reset while channel 2 sits at cnt=4 in RISE_CHK.
        bn[2] = 1'b1;
        repeat (8) cycle();
        rst = 1'b1;
        cycle();
        chk("midrst_level2", level[2], 1'b0);
        chk("midrst_rise", rise, 16'h0);
        cycle();
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            cycle();
            chk("midrst_rerise", rise, (e == 13) ? 16'h8007 : 16'h0);
            chk("midrst_level2_after", level[2], (e >= 13) ? 1'b1 : 1'b0);
        end

        // Randomized traffic: alternating bouncy and calm phases, random tick, rare reset.
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
            tick = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < N; i++) begin
                if (((k / 500) % 2) == 0) begin
                    if ($urandom_range(0, 7) == 0) bn[i] = ~bn[i];
                end else begin
                    if ($urandom_range(0, 39) == 0) bn[i] = ~bn[i];
                end
            end
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
